// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of the request FIFOs in front of the CGRA shared memory.
// One word per transaction: pop, wait a cycle for registered read data, then send tagged with its source.
module fifo_drain_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            en,
   input  logic [NUM_PORTS-1:0]            fifo_req,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_rd_data,
   output logic [NUM_PORTS-1:0]            fifo_rd_en,
   output logic [NUM_PORTS-1:0]            gnt_vec,
   output logic                            mem_valid,
   input  logic                            mem_ready,
   output logic [DATA_WIDTH-1:0]           mem_wdata,
   output logic [ID_WIDTH-1:0]             mem_id,
   output logic                            busy
);

   typedef enum logic [1:0] {IDLE, POP, LATCH, SEND} state_t;

   state_t              state;
   state_t              next_state;
   logic [ID_WIDTH-1:0] rr_ptr;
   logic [ID_WIDTH-1:0] win_idx;
   logic                win_found;
   logic                grant;

   // First requesting FIFO at or after rr_ptr, wrapping modulo NUM_PORTS.
   always_comb begin
      int                  cand;
      logic [ID_WIDTH-1:0] cand_idx;
      cand      = 0;
      cand_idx  = '0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int off = 0; off < NUM_PORTS; off++) begin
         cand = int'(rr_ptr) + off;
         if (cand >= NUM_PORTS) begin
            cand = cand - NUM_PORTS;
         end
         cand_idx = ID_WIDTH'(cand);
         if (!win_found && fifo_req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   assign grant = (state == IDLE) && en && win_found;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (grant) next_state = POP;
         POP:     next_state = LATCH;
         LATCH:   next_state = SEND;
         SEND:    if (mem_valid && mem_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Registered strobes and datapath; the grant and source id are frozen until SEND completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_rd_en <= '0;
         gnt_vec    <= '0;
         mem_valid  <= 1'b0;
         mem_wdata  <= '0;
         mem_id     <= '0;
         rr_ptr     <= '0;
      end else begin
         fifo_rd_en <= '0;
         case (state)
            IDLE: begin
               if (grant) begin
                  fifo_rd_en <= NUM_PORTS'(1) << win_idx;
                  gnt_vec    <= NUM_PORTS'(1) << win_idx;
                  mem_id     <= win_idx;
                  rr_ptr     <= (win_idx == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
               end
            end
            LATCH: begin
               mem_wdata <= fifo_rd_data[mem_id*DATA_WIDTH +: DATA_WIDTH];
               mem_valid <= 1'b1;
            end
            SEND: begin
               if (mem_valid && mem_ready) begin
                  mem_valid <= 1'b0;
                  gnt_vec   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy = (state != IDLE);
   end

endmodule
